// File: rtl/cursor_overlay.sv
`timescale 1ns/1ps
// cursor_overlay: 32x32, 2-bpp hardware cursor blended onto the formatter's
// DVI pixel stream. Fixed 3-cycle latency: read/hit stage, code select, mix.
// Optional feature: define CURSOR_INVERT_EN to make code 3 invert the pixel;
// without it code 3 is transparent.
module cursor_overlay #(
    parameter int unsigned CUR_W = 32,
    parameter int unsigned CUR_H = 32
) (
    input  logic        dvi_clk,
    input  logic        reset,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_active_video,
    input  logic [31:0] in_rgb,
    input  logic        sync_polarity,
    input  logic        control_strobe,
    input  logic [7:0]  control_op,
    input  logic [31:0] control_data,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_active_video,
    output logic [31:0] out_rgb
);

    typedef enum logic [7:0] {
        OP_ENABLE = 8'd1,
        OP_POS    = 8'd2,
        OP_COLOR  = 8'd3,
        OP_ADDR   = 8'd4,
        OP_DATA   = 8'd5
    } ctl_op_e;

    // Control, shadow and raster state
    logic        live_en_q, live_en_d, shadow_en_q, shadow_en_d;
    logic [11:0] live_x_q, live_x_d, live_y_q, live_y_d;
    logic [11:0] shadow_x_q, shadow_x_d, shadow_y_q, shadow_y_d;
    logic [23:0] color0_q, color0_d, color1_q, color1_d;
    logic [5:0]  waddr_q, waddr_d;
    logic        vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
    logic [11:0] rx_q, rx_d, ry_q, ry_d;
    logic        ram_we, vs_act, vs_rise, de_fall;

    // Pipeline state
    logic [12:0] dx, dy;
    logic [5:0]  raddr;
    logic [31:0] rd_data_q;
    logic [3:0]  s1_dx_q, s1_dx_d;
    logic        s1_hit_q, s1_hit_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_de_q, s1_de_d;
    logic [31:0] s1_rgb_q, s1_rgb_d;
    logic [1:0]  s2_code_q, s2_code_d, code_sel;
    logic        s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d, s2_de_q, s2_de_d;
    logic [31:0] s2_rgb_q, s2_rgb_d;
    logic        out_hs_q, out_hs_d, out_vs_q, out_vs_d, out_de_q, out_de_d;
    logic [31:0] out_rgb_q, out_rgb_d;

    logic [31:0] mem [64];

    // Control decode, vsync shadow latch and raster position tracking
    always_comb begin
        live_en_d   = live_en_q;
        live_x_d    = live_x_q;
        live_y_d    = live_y_q;
        shadow_en_d = shadow_en_q;
        shadow_x_d  = shadow_x_q;
        shadow_y_d  = shadow_y_q;
        color0_d    = color0_q;
        color1_d    = color1_q;
        waddr_d     = waddr_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        ram_we      = 1'b0;

        vs_act    = in_vsync ^ sync_polarity;
        vs_rise   = vs_act & ~vs_prev_q;
        de_fall   = de_prev_q & ~in_active_video;
        vs_prev_d = vs_act;
        de_prev_d = in_active_video;

        if (control_strobe) begin
            case (control_op)
                OP_ENABLE: live_en_d = control_data[0];
                OP_POS: begin
                    live_y_d = control_data[27:16];
                    live_x_d = control_data[11:0];
                end
                OP_COLOR: begin
                    if (control_data[24]) color1_d = control_data[23:0];
                    else                  color0_d = control_data[23:0];
                end
                OP_ADDR: waddr_d = control_data[5:0];
                OP_DATA: begin
                    ram_we  = 1'b1;
                    waddr_d = waddr_q + 6'd1;
                end
                default: ;
            endcase
        end

        if (de_fall) begin
            rx_d = '0;
            if (ry_q != '1) ry_d = ry_q + 12'd1;
        end else if (in_active_video && rx_q != '1) begin
            rx_d = rx_q + 12'd1;
        end

        // Shadow takes the pre-strobe live values so a same-cycle POS waits a frame
        if (vs_rise) begin
            shadow_en_d = live_en_q;
            shadow_x_d  = live_x_q;
            shadow_y_d  = live_y_q;
            ry_d        = '0;
        end
    end

    // Stage 1: cursor-relative position, hit test and bitmap word address
    always_comb begin
        dx       = {1'b0, rx_q} - {1'b0, shadow_x_q};
        dy       = {1'b0, ry_q} - {1'b0, shadow_y_q};
        // Negative offsets have bit 12 set, so one unsigned compare covers both bounds
        s1_hit_d = shadow_en_q & in_active_video & (dx < 13'(CUR_W)) & (dy < 13'(CUR_H));
        raddr    = {dy[4:0], dx[4]};
        s1_dx_d  = dx[3:0];
        s1_hs_d  = in_hsync;
        s1_vs_d  = in_vsync;
        s1_de_d  = in_active_video;
        s1_rgb_d = in_rgb;
    end

    // Stage 2: pick the 2-bit pixel code out of the fetched word
    always_comb begin
        code_sel  = rd_data_q[{s1_dx_q, 1'b0} +: 2];
        s2_code_d = s1_hit_q ? code_sel : 2'b00;
        s2_hs_d   = s1_hs_q;
        s2_vs_d   = s1_vs_q;
        s2_de_d   = s1_de_q;
        s2_rgb_d  = s1_rgb_q;
    end

    // Stage 3: mix the cursor colour into the pixel
    always_comb begin
        out_hs_d  = s2_hs_q;
        out_vs_d  = s2_vs_q;
        out_de_d  = s2_de_q;
        out_rgb_d = s2_rgb_q;
        case (s2_code_q)
            2'd1: out_rgb_d = {s2_rgb_q[31:24], color0_q};
            2'd2: out_rgb_d = {s2_rgb_q[31:24], color1_q};
`ifdef CURSOR_INVERT_EN
            2'd3: out_rgb_d = {s2_rgb_q[31:24], ~s2_rgb_q[23:0]};
`endif
            default: ;
        endcase
    end

    // State and pipeline registers
    always_ff @(posedge dvi_clk or posedge reset) begin
        if (reset) begin
            live_en_q   <= 1'b0;
            live_x_q    <= '0;
            live_y_q    <= '0;
            shadow_en_q <= 1'b0;
            shadow_x_q  <= '0;
            shadow_y_q  <= '0;
            color0_q    <= '0;
            color1_q    <= '1;
            waddr_q     <= '0;
            vs_prev_q   <= 1'b0;
            de_prev_q   <= 1'b0;
            rx_q        <= '0;
            ry_q        <= '0;
            s1_dx_q     <= '0;
            s1_hit_q    <= 1'b0;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            s1_de_q     <= 1'b0;
            s1_rgb_q    <= '0;
            s2_code_q   <= '0;
            s2_hs_q     <= 1'b0;
            s2_vs_q     <= 1'b0;
            s2_de_q     <= 1'b0;
            s2_rgb_q    <= '0;
            out_hs_q    <= 1'b0;
            out_vs_q    <= 1'b0;
            out_de_q    <= 1'b0;
            out_rgb_q   <= '0;
        end else begin
            live_en_q   <= live_en_d;
            live_x_q    <= live_x_d;
            live_y_q    <= live_y_d;
            shadow_en_q <= shadow_en_d;
            shadow_x_q  <= shadow_x_d;
            shadow_y_q  <= shadow_y_d;
            color0_q    <= color0_d;
            color1_q    <= color1_d;
            waddr_q     <= waddr_d;
            vs_prev_q   <= vs_prev_d;
            de_prev_q   <= de_prev_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            s1_dx_q     <= s1_dx_d;
            s1_hit_q    <= s1_hit_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            s1_de_q     <= s1_de_d;
            s1_rgb_q    <= s1_rgb_d;
            s2_code_q   <= s2_code_d;
            s2_hs_q     <= s2_hs_d;
            s2_vs_q     <= s2_vs_d;
            s2_de_q     <= s2_de_d;
            s2_rgb_q    <= s2_rgb_d;
            out_hs_q    <= out_hs_d;
            out_vs_q    <= out_vs_d;
            out_de_q    <= out_de_d;
            out_rgb_q   <= out_rgb_d;
        end
    end

    // Bitmap RAM, read-first, contents not reset
    always_ff @(posedge dvi_clk) begin
        if (ram_we) mem[waddr_q] <= control_data;
        rd_data_q <= mem[raddr];
    end

    assign out_hsync        = out_hs_q;
    assign out_vsync        = out_vs_q;
    assign out_active_video = out_de_q;
    assign out_rgb          = out_rgb_q;

endmodule

// File: tb/tb_cursor_overlay.sv
`timescale 1ns/1ps
// Scoreboard bench for cursor_overlay: random pixels on a reduced raster,
// expected output predicted from screen coordinates and cursor register model.
module tb_cursor_overlay;

    localparam int H_ACT = 136, HFP = 2, HS = 4, H_TOT = 144;
    localparam int V_ACT = 84, VFP = 1, VS = 1, V_TOT = 87;
    localparam int NFRAMES = 5;

    logic        dvi_clk, reset;
    logic        in_hsync, in_vsync, in_active_video, sync_polarity;
    logic [31:0] in_rgb;
    logic        control_strobe;
    logic [7:0]  control_op;
    logic [31:0] control_data;
    logic        out_hsync, out_vsync, out_active_video;
    logic [31:0] out_rgb;

    cursor_overlay #(.CUR_W(32), .CUR_H(32)) dut (
        .dvi_clk(dvi_clk), .reset(reset),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_active_video(in_active_video),
        .in_rgb(in_rgb), .sync_polarity(sync_polarity),
        .control_strobe(control_strobe), .control_op(control_op), .control_data(control_data),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_active_video(out_active_video),
        .out_rgb(out_rgb)
    );

    initial dvi_clk = 1'b0;
    always #5 dvi_clk = ~dvi_clk;

    typedef struct { int unsigned edge_no; logic [34:0] val; } exp_t;
    typedef struct { logic [7:0] op; logic [31:0] data; } ctl_t;
    exp_t exp_q[$];
    ctl_t ctl_q[$];
    int unsigned n_cmp = 0, n_bad = 0, edge_n = 0;

    // Reference model: cursor registers and bitmap as plain variables
    bit          m_live_en, m_sh_en, m_vs_prev;
    int          m_live_x, m_live_y, m_sh_x, m_sh_y, m_waddr;
    logic [23:0] m_c0, m_c1;
    logic [31:0] m_mem [64];

    task automatic model_reset();
        m_live_en = 0; m_sh_en = 0; m_vs_prev = 0;
        m_live_x = 0; m_live_y = 0; m_sh_x = 0; m_sh_y = 0; m_waddr = 0;
        m_c0 = 24'h000000; m_c1 = 24'hFFFFFF;
    endtask

    function automatic logic [34:0] model_pixel(bit hs, bit vs, bit de, logic [31:0] rgb,
                                                int col, int line);
        logic [31:0] o, word;
        int dx, dy, code;
        o = rgb;
        dx = col - m_sh_x;
        dy = line - m_sh_y;
        if (de && m_sh_en && dx >= 0 && dx < 32 && dy >= 0 && dy < 32) begin
            word = m_mem[dy * 2 + dx / 16];
            code = int'((word >> (2 * (dx % 16))) & 32'd3);
            if (code == 1) o = {rgb[31:24], m_c0};
            else if (code == 2) o = {rgb[31:24], m_c1};
`ifdef CURSOR_INVERT_EN
            else if (code == 3) o = {rgb[31:24], ~rgb[23:0]};
`endif
        end
        return {hs, vs, de, o};
    endfunction

    task automatic model_ctl(input logic [7:0] op, input logic [31:0] d);
        case (op)
            8'd1: m_live_en = d[0];
            8'd2: begin m_live_y = int'(d[27:16]); m_live_x = int'(d[11:0]); end
            8'd3: if (d[24]) m_c1 = d[23:0]; else m_c0 = d[23:0];
            8'd4: m_waddr = int'(d[5:0]);
            8'd5: begin m_mem[m_waddr] = d; m_waddr = (m_waddr + 1) % 64; end
            default: ;
        endcase
    endtask

    task automatic push_ctl(input logic [7:0] op, input logic [31:0] d);
        ctl_t c;
        c.op = op; c.data = d;
        ctl_q.push_back(c);
    endtask

    // One pixel slot: drive inputs, predict the output three edges later, update model
    task automatic drive_cycle(input bit hs_a, input bit vs_a, input bit de, input int col, input int line);
        exp_t e;
        ctl_t c;
        bit strobe;
        @(posedge dvi_clk);
        #2;
        reset           = 1'b0;
        in_rgb          = $urandom;
        in_hsync        = hs_a ^ sync_polarity;
        in_vsync        = vs_a ^ sync_polarity;
        in_active_video = de;
        strobe          = (ctl_q.size() > 0);
        if (strobe) begin
            c = ctl_q.pop_front();
            control_op   = c.op;
            control_data = c.data;
        end else begin
            control_op   = 8'($urandom);
            control_data = $urandom;
        end
        control_strobe = strobe;
        e.edge_no = edge_n + 1;
        e.val     = model_pixel(hs_a ^ sync_polarity, vs_a ^ sync_polarity, de, in_rgb, col, line);
        exp_q.push_back(e);
        if (vs_a && !m_vs_prev) begin
            m_sh_en = m_live_en; m_sh_x = m_live_x; m_sh_y = m_live_y;
        end
        m_vs_prev = vs_a;
        if (strobe) model_ctl(control_op, control_data);
    endtask

    task automatic reset_pulse();
        @(posedge dvi_clk);
        #2;
        reset = 1'b1;
        control_strobe = 1'b0;
        exp_q.delete();
        ctl_q.delete();
        model_reset();
        repeat (3) @(posedge dvi_clk);
    endtask

    task automatic schedule(input int f, input int line);
        logic [31:0] d;
        if (f == 0 && line == 0) begin
            push_ctl(8'd4, 32'h0000_0000);
            for (int i = 0; i < 64; i++) push_ctl(8'd5, 32'h5555_5555);
            push_ctl(8'd3, 32'h0000_FF00);
            push_ctl(8'd3, 32'h01FF_FFFF);
            push_ctl(8'd2, 32'h0032_0064 | ($urandom & 32'hF000_F000));
            push_ctl(8'd1, 32'h0000_0001);
            push_ctl(8'd0, $urandom);
            push_ctl(8'd6, $urandom);
        end
        if (f == 1 && line == 20) push_ctl(8'd2, 32'h0032_0028);
        if (f == 1 && line == 70) begin
            push_ctl(8'd4, 32'h0000_003F);
            push_ctl(8'd5, $urandom);
            push_ctl(8'd5, 32'h0000_000B);
            for (int i = 0; i < 63; i++) push_ctl(8'd5, $urandom);
        end
        if (f == 2 && line == 0) begin
            push_ctl(8'd2, 32'(((V_ACT - 10) << 16) | (H_ACT - 20)));
            push_ctl(8'hFF, 32'h0000_0000);
        end
        if (f == 3 && line == 0) begin
            d = $urandom; d[24] = 1'b0; push_ctl(8'd3, d);
            d = $urandom; d[24] = 1'b1; push_ctl(8'd3, d);
        end
        if (f == 3 && line == 40) push_ctl(8'd1, 32'hFFFF_FFFE);
    endtask

    // Monitor: count edges, compare each output slot against the scoreboard
    initial begin
        exp_t e;
        logic [34:0] act;
        forever begin
            @(posedge dvi_clk);
            edge_n++;
            @(negedge dvi_clk);
            act = {out_hsync, out_vsync, out_active_video, out_rgb};
            if (reset) begin
                n_cmp++;
                if (act !== 35'd0) begin
                    n_bad++;
                    $display("FAIL reset_state edge %0d: got %h, expected 0", edge_n, act);
                end
            end else begin
                while (exp_q.size() > 0 && exp_q[0].edge_no + 2 <= edge_n) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (act !== e.val) begin
                        n_bad++;
                        $display("FAIL pixel edge %0d: got hs=%b vs=%b de=%b rgb=%h, expected hs=%b vs=%b de=%b rgb=%h",
                                 edge_n, act[34], act[33], act[32], act[31:0],
                                 e.val[34], e.val[33], e.val[32], e.val[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, %0d items pending", exp_q.size());
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        sync_polarity   = 1'($urandom_range(0, 1));
        reset           = 1'b1;
        in_hsync        = sync_polarity;
        in_vsync        = sync_polarity;
        in_active_video = 1'b0;
        in_rgb          = '0;
        control_strobe  = 1'b0;
        control_op      = '0;
        control_data    = '0;
        model_reset();
        repeat (3) @(posedge dvi_clk);

        for (int f = 0; f < NFRAMES; f++) begin
            for (int line = 0; line < V_TOT; line++) begin
                schedule(f, line);
                for (int col = 0; col < H_TOT; col++) begin
                    if (f == NFRAMES - 1 && line == 40 && col == 10) reset_pulse();
                    drive_cycle(col >= H_ACT + HFP && col < H_ACT + HFP + HS,
                                line >= V_ACT + VFP && line < V_ACT + VFP + VS,
                                line < V_ACT && col < H_ACT, col, line);
                end
            end
        end

        repeat (4) @(posedge dvi_clk);
        @(negedge dvi_clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected outputs never compared, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cursor_overlay.md
Name: cursor_overlay

Overview:
- Hardware mouse-cursor overlay, placed directly downstream of the video stream formatter in the dvi_clk domain.
- Consumes the formatter's hsync/vsync/active_video/rgb outputs and tracks raster position from them.
- Blends a 32x32, 2-bit-per-pixel cursor bitmap onto the stream and drives the TMDS/DVI output stage.
- All outputs are delayed by a fixed 3-cycle pipeline.

Parameters:
- CUR_W, 32, cursor width in pixels (fixed layout assumes 32)
- CUR_H, 32, cursor height in lines
- PIPE, 3, pipeline latency in cycles (informational; not overridable)

Ports:
- dvi_clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- in_hsync  in  1  hsync from formatter (polarity per sync_polarity)
- in_vsync  in  1  vsync from formatter
- in_active_video  in  1  data-enable from formatter
- in_rgb  in  32  pixel {8'b0,B,G,R}
- sync_polarity  in  1  1 = syncs active-low
- control_strobe  in  1  one-cycle qualifier for control_op/control_data
- control_op  in  8  1=ENABLE, 2=POS, 3=COLOR, 4=ADDR, 5=DATA
- control_data  in  32  operand
- out_hsync  out  1  in_hsync delayed 3
- out_vsync  out  1  in_vsync delayed 3
- out_active_video  out  1  in_active_video delayed 3
- out_rgb  out  32  blended pixel

Behaviour:
- Reset: out_hsync/out_vsync/out_active_video = 0, out_rgb = 0; enable = 0; pos x = 0, y = 0 (live and shadow); color0 = 0x000000, color1 = 0xFFFFFF; word address = 0; raster x/y = 0. Bitmap RAM is not reset.
- Control is applied only when control_strobe = 1. Other op codes are ignored.
  - ENABLE: live_en <= data[0].
  - POS: live_y <= data[27:16]; live_x <= data[11:0].
  - COLOR: data[24] selects color0/color1; value <= data[23:0].
  - ADDR: waddr <= data[5:0].
  - DATA: ram[waddr] <= data; waddr <= waddr + 1, wrapping 63 -> 0.
- Bitmap layout:
  - Word a holds row a[5:1]; pixels 0-15 when a[0] = 0, pixels 16-31 when a[0] = 1.
  - Pixel p of a word occupies bits [2p+1:2p].
  - Codes: 0 = transparent, 1 = color0, 2 = color1, 3 = invert.
- Vsync edge: vs_act = in_vsync ^ sync_polarity. On its rising edge, shadow_en/x/y <= live values and ry <= 0. Positions and enable written mid-frame therefore take effect at the next frame. A POS strobe on the same cycle as the edge lands in live only.
- Raster counters:
  - rx counts active pixels within a line, 0 at the first active pixel.
  - On the falling edge of in_active_video: rx <= 0 and ry <= ry + 1 (12-bit, saturating at 4095).
- Stage 1:
  - dx = rx - sx and dy = ry - sy, computed 13-bit.
  - hit = shadow_en & in_active_video & 0 <= dx < 32 & 0 <= dy < 32. Compute the bounds in 13 bits so sx near 4095 does not wrap.
  - Issue the RAM read at {dy[4:0], dx[4]}. Register dx[3:0], hit, syncs and rgb.
- Stage 2: select the 2-bit code using dx[3:0]; force code 0 if !hit.
- Stage 3: mix.
  - 0 -> in_rgb.
  - 1 -> {in_rgb[31:24], color0}.
  - 2 -> {in_rgb[31:24], color1}.
  - 3 -> see Optional Feature.
- A RAM write and read to the same word in the same cycle returns old data (read-first). Mid-line tearing of bitmap writes is accepted.
- Clipping: cursor pixels beyond the active region are never shown, because only active pixels are counted.
- Blanking: out_rgb passes in_rgb delayed 3 when out_active_video = 0; no cursor is applied there.
- Reset asserted mid-frame: the pipeline clears immediately. After release, the raster counters are unsynchronised until the next vsync edge; no cursor is shown until then, because the shadow enable = 0.

Optional Feature:
- Macro: CURSOR_INVERT_EN.
- Defined: code 3 outputs {in_rgb[31:24], ~in_rgb[23:0]}.
- Undefined: code 3 is treated as transparent and the invert logic is absent.

Test Plan:
- Reset, then drive 640x480 timing with in_rgb = 0x00123456, cursor disabled -> out_rgb equals in_rgb delayed exactly 3 cycles; syncs and active_video likewise delayed 3.
- ADDR 0, then 64 DATA writes of 0x55555555, color0 = 0x00FF00, POS x = 100 y = 50, ENABLE 1, then one vsync -> pixels (100..131, 50..81) = 0x0000FF00; pixel (99, 50) and (132, 50) = 0x00123456.
- POS written to x = 200 mid-frame -> current frame still shows the cursor at x = 100; next frame at x = 200.
- POS x = 620 y = 470 -> only columns 620..639 and rows 470..479 modified; no wrap artefacts at x = 0 or y = 0.
- Word 0 = 0x0000000B (pixel0 = 3, pixel1 = 2) with color1 = 0xFFFFFF -> with CURSOR_INVERT_EN, pixel0 = 0x00EDCBA9 and pixel1 = 0x00FFFFFF; without the macro, pixel0 = 0x00123456.
- 65 consecutive DATA writes from ADDR 63 -> the first write lands in word 63 and the rest wrap through 0..63; read-back via display matches, and word 63 ends with the value of the 65th write.
